// File: rtl/packet_uart_tx.sv
// Byte-serial UART transmitter for the assembled game-state packet (8N1, byte 0 first).
// Define PACKET_UART_TX_CHECKSUM_EN to append an XOR checksum byte after the last packet byte.
module packet_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PACKET_BYTES = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*PACKET_BYTES-1:0] packet,
  input  logic                      send,
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);

  localparam int PKT_W  = 8 * PACKET_BYTES;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef PACKET_UART_TX_CHECKSUM_EN
  localparam int WIRE_BYTES = PACKET_BYTES + 1;
`else
  localparam int WIRE_BYTES = PACKET_BYTES;
`endif
  localparam int IDX_W = $clog2(WIRE_BYTES + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIRE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [BAUD_W-1:0]  baud_r, baud_s;
  logic [2:0]         bit_r, bit_s;
  logic [IDX_W-1:0]   byte_r, byte_s;
  logic [PKT_W-1:0]   shadow_r;
  logic               load_s;
  logic               done_s;
  logic               tx_s;
  logic [7:0]         wire_byte_s;
  logic               tx_r, busy_r, done_r;

  function automatic logic [7:0] pick_byte(input logic [PKT_W-1:0] p,
                                           input logic [IDX_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < PACKET_BYTES; i++) begin
      r = (idx == IDX_W'(i)) ? p[8*i +: 8] : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [PKT_W-1:0] p);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < PACKET_BYTES; i++) begin
      r = r ^ p[8*i +: 8];
    end
    return r;
  endfunction

  // Next-state logic; every bit period ends on the baud-counter wrap.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    byte_s  = byte_r;
    load_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        baud_s = '0;
        bit_s  = 3'd0;
        byte_s = '0;
        if (send) begin
          load_s  = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (byte_r < IDX_LAST) begin
            byte_s  = byte_r + IDX_W'(1);
            state_s = START;
          end else begin
            byte_s  = '0;
            done_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
        byte_s  = '0;
      end
    endcase
  end

  // Line level for the next cycle, derived from the next state so tx is a plain register.
  always_comb begin
    tx_s        = 1'b1;
    wire_byte_s = 8'h00;
    case (state_s)
      IDLE:  tx_s = 1'b1;
      START: tx_s = 1'b0;
      DATA: begin
`ifdef PACKET_UART_TX_CHECKSUM_EN
        if (byte_s == IDX_W'(PACKET_BYTES)) begin
          wire_byte_s = xor_bytes(shadow_r);
        end else begin
          wire_byte_s = pick_byte(shadow_r, byte_s);
        end
`else
        wire_byte_s = pick_byte(shadow_r, byte_s);
`endif
        tx_s = wire_byte_s[bit_s];
      end
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      byte_r  <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      byte_r  <= byte_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
    end
  end

  // Packet snapshot, taken only when a frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= '0;
    end else if (load_s) begin
      shadow_r <= packet;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_packet_uart_tx.sv
// Scoreboard bench for packet_uart_tx: stimulus queues expected bytes, a UART decoder
// pops and compares them, and a done monitor checks frame timing.
module tb_packet_uart_tx;

  localparam int CPB   = 4;
  localparam int PB    = 22;
  localparam int PKT_W = 8 * PB;
`ifdef PACKET_UART_TX_CHECKSUM_EN
  localparam int WIRE_BYTES = PB + 1;
`else
  localparam int WIRE_BYTES = PB;
`endif
  localparam int FRAME_CYC = 10 * CPB * WIRE_BYTES;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             send = 1'b0;
  logic [PKT_W-1:0] packet = '0;
  logic             tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  packet_uart_tx #(.CLKS_PER_BIT(CPB), .PACKET_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .packet(packet), .send(send),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [PKT_W-1:0] p);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < PB; i++) begin
      exp_q.push_back(p[8*i +: 8]);
      x = x ^ p[8*i +: 8];
    end
`ifdef PACKET_UART_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic send_frame(input logic [PKT_W-1:0] p);
    @(negedge clk);
    packet = p;
    send   = 1'b1;
    push_frame(p);
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, " done reached"}, 32'(seen), 32'd1);
  endtask

  // UART decoder: samples every cycle, checks bit widths, pops the scoreboard per byte
  initial begin : uart_mon
    logic prev, ab, bad_start, unstable, bad_stop;
    logic [7:0] v, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        ab = 1'b0; bad_start = 1'b0; unstable = 1'b0; bad_stop = 1'b0; v = 8'h00;
        for (int s = 1; s < CPB && !ab; s++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
          else if (tx !== 1'b0) bad_start = 1'b1;
        end
        for (int b = 0; b < 8 && !ab; b++) begin
          for (int s = 0; s < CPB && !ab; s++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
            else if (s == 0) v[b] = tx;
            else if (tx !== v[b]) unstable = 1'b1;
          end
        end
        for (int s = 0; s < CPB && !ab; s++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
          else if (tx !== 1'b1) bad_stop = 1'b1;
        end
        if (!ab) begin
          check("start bit low", 32'(bad_start), 32'd0);
          check("data bit stable", 32'(unstable), 32'd0);
          check("stop bit high", 32'(bad_stop), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected byte: got %0h expected none", v);
          end else begin
            e = exp_q.pop_front();
            check("decoded byte", 32'(v), 32'(e));
          end
        end
        prev = rst ? 1'b1 : tx;
      end else begin
        prev = tx;
      end
    end
  end

  // Done monitor: pulse width, idle line and accept-to-done distance
  initial begin : done_mon
    logic busy_prev, done_prev, acc_ok;
    int acc;
    busy_prev = 1'b0; done_prev = 1'b0; acc_ok = 1'b0; acc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0; done_prev = 1'b0; acc_ok = 1'b0;
      end else begin
        if (!busy_prev && busy) begin
          acc    = cyc;
          acc_ok = 1'b1;
        end
        if (done) begin
          done_cnt++;
          check("done single cycle", 32'(done_prev), 32'd0);
          check("busy low at done", 32'(busy), 32'd0);
          check("tx high at done", 32'(tx), 32'd1);
          check("frame length", acc_ok ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'(FRAME_CYC));
          acc_ok = 1'b0;
        end
        busy_prev = busy;
        done_prev = done;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [PKT_W-1:0] p;
    logic seen;
    int dc0;

    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // header 0x55AA, player x/y, zeros elsewhere: wire bytes AA 55 12 34 00...
    p = '0;
    p[15:0]  = 16'h55AA;
    p[23:16] = 8'h12;
    p[31:24] = 8'h34;
    send_frame(p);
    check("busy after accept", 32'(busy), 32'd1);
    check("tx low after accept", 32'(tx), 32'd0);
    wait_done("single");
    repeat (3) @(negedge clk);

    p = '0;
    p[7:0] = 8'h01;
    send_frame(p);
    wait_done("bit order");
    repeat (3) @(negedge clk);

    p = '0;
    for (int j = 0; j < PB; j++) p[8*j +: 8] = 8'(8'h3C + 8'(j * 7));
    send_frame(p);
    seen = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else for (int j = 0; j < PB; j++) packet[8*j +: 8] = 8'($urandom());
    end
    check("snapshot done reached", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);

    dc0 = done_cnt;
    p = '0;
    p[15:0] = 16'h55AA;
    p[47:32] = 16'hBEEF;
    send_frame(p);
    repeat (99) @(negedge clk);
    packet = ~p;
    send   = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (399) @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_done("busy ignore");
    repeat (20) @(negedge clk);
    check("no queued frame", 32'(busy), 32'd0);
    check("busy ignore done count", 32'(done_cnt - dc0), 32'd1);

    dc0 = done_cnt;
    p = '0;
    p[15:0] = 16'h55AA;
    p[175:168] = 8'h81;
    @(negedge clk);
    packet = p;
    send   = 1'b1;
    push_frame(p);
    push_frame(p);
    wait_done("back-to-back 1");
    wait_done("back-to-back 2");
    send = 1'b0;
    repeat (20) @(negedge clk);
    check("continuous stops", 32'(busy), 32'd0);
    check("continuous done count", 32'(done_cnt - dc0), 32'd2);

    // reset in the middle of byte 2 (all zero, so the line is low)
    dc0 = done_cnt;
    p = '0;
    p[7:0]  = 8'hF0;
    p[15:8] = 8'hC3;
    @(negedge clk);
    packet = p;
    send   = 1'b1;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hC3);
    @(negedge clk);
    send = 1'b0;
    repeat (93) @(negedge clk);
    check("pre-reset tx data low", 32'(tx), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("async reset tx", 32'(tx), 32'd1);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset tx", 32'(tx), 32'd1);
    check("post-reset no done", 32'(done_cnt - dc0), 32'd0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
